// File: rtl/flash_page_read_sequencer.sv
// Page-read command sequencer: turns one host request into CMD 0x00, five address
// cycles, CMD 0x30, a tWB guard, a ready wait and N word reads via the timing controller.
module flash_page_read_sequencer #(
  parameter int WORD_COUNT_WIDTH = 12,
  parameter int TWB_CYCLES       = 8,
  parameter int TIMEOUT_CYCLES   = 65535
) (
  input  logic                        i_master_clk,
  input  logic                        i_reset_n,
  input  logic                        i_page_request,
  input  logic [15:0]                 i_col_addr,
  input  logic [23:0]                 i_row_addr,
  input  logic [WORD_COUNT_WIDTH-1:0] i_word_count,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_error,
  output logic [15:0]                 o_data,
  output logic                        o_data_valid,
  input  logic                        i_data_ready,
  output logic                        o_cmd_request,
  output logic [7:0]                  o_cmd_data,
  input  logic                        i_cmd_done,
  output logic                        o_ad_request,
  output logic [7:0]                  o_ad_data,
  input  logic                        i_ad_done,
  output logic                        o_rd_request,
  input  logic [15:0]                 i_rd_data,
  input  logic                        i_rd_data_valid,
  input  logic                        i_chip_ready,
  output logic [3:0]                  o_fsm_state
);

  localparam int TWB_W = $clog2(TWB_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD1, S_ADDR, S_CMD2, S_TWB, S_WAIT_RDY, S_READ, S_FINISH, S_ERROR
  } state_t;

  state_t                      state;
  logic [15:0]                 col_q;
  logic [23:0]                 row_q;
  logic [WORD_COUNT_WIDTH-1:0] word_cnt;
  logic [2:0]                  ad_idx;
  logic [TWB_W-1:0]            twb_cnt;
  logic [TMO_W-1:0]            tmo_cnt;
  logic [7:0]                  addr_byte;

  assign o_fsm_state = state;

  always_comb begin
    addr_byte = col_q[7:0];
    case (ad_idx)
      3'd1:    addr_byte = col_q[15:8];
      3'd2:    addr_byte = row_q[7:0];
      3'd3:    addr_byte = row_q[15:8];
      3'd4:    addr_byte = row_q[23:16];
      default: addr_byte = col_q[7:0];
    endcase
  end

  // Handshake: a request rises only while it is low, is held (with its byte stable)
  // until done/valid is sampled, drops on that same edge, and so every request sees
  // at least one low cycle before the next one can rise.
  always_ff @(posedge i_master_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= S_IDLE;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_error       <= 1'b0;
      o_data        <= 16'h0000;
      o_data_valid  <= 1'b0;
      o_cmd_request <= 1'b0;
      o_cmd_data    <= 8'h00;
      o_ad_request  <= 1'b0;
      o_ad_data     <= 8'h00;
      o_rd_request  <= 1'b0;
      col_q         <= 16'h0000;
      row_q         <= 24'h000000;
      word_cnt      <= '0;
      ad_idx        <= 3'd0;
      twb_cnt       <= '0;
      tmo_cnt       <= '0;
    end else begin
      o_done       <= 1'b0;
      o_error      <= 1'b0;
      o_data_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_page_request) begin
            col_q    <= i_col_addr;
            row_q    <= i_row_addr;
            word_cnt <= i_word_count;
            o_busy   <= 1'b1;
            state    <= S_CMD1;
          end
        end
        S_CMD1: begin
          if (!o_cmd_request) begin
            o_cmd_request <= 1'b1;
            o_cmd_data    <= 8'h00;
          end else if (i_cmd_done) begin
            o_cmd_request <= 1'b0;
            ad_idx        <= 3'd0;
            state         <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (!o_ad_request) begin
            o_ad_request <= 1'b1;
            o_ad_data    <= addr_byte;
          end else if (i_ad_done) begin
            o_ad_request <= 1'b0;
            if (ad_idx == 3'd4) state <= S_CMD2;
            else ad_idx <= ad_idx + 3'd1;
          end
        end
        S_CMD2: begin
          if (!o_cmd_request) begin
            o_cmd_request <= 1'b1;
            o_cmd_data    <= 8'h30;
          end else if (i_cmd_done) begin
            o_cmd_request <= 1'b0;
            twb_cnt       <= '0;
            state         <= S_TWB;
          end
        end
        S_TWB: begin
          // R/B# is not trustworthy until the chip has had tWB to pull it low.
          if (twb_cnt == TWB_W'(TWB_CYCLES - 1)) begin
            tmo_cnt <= '0;
            state   <= S_WAIT_RDY;
          end else begin
            twb_cnt <= twb_cnt + TWB_W'(1);
          end
        end
        S_WAIT_RDY: begin
          if (i_chip_ready) begin
            state <= (word_cnt == '0) ? S_FINISH : S_READ;
          end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state <= S_ERROR;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_READ: begin
          if (o_rd_request) begin
            if (i_rd_data_valid) begin
              o_rd_request <= 1'b0;
              o_data       <= i_rd_data;
              o_data_valid <= 1'b1;
              word_cnt     <= word_cnt - WORD_COUNT_WIDTH'(1);
              if (word_cnt == WORD_COUNT_WIDTH'(1)) state <= S_FINISH;
            end
          end else if (i_data_ready && word_cnt != '0) begin
            o_rd_request <= 1'b1;
          end
        end
        S_FINISH: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        S_ERROR: begin
          o_error <= 1'b1;
          o_busy  <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_page_read_sequencer.sv
// Bench for flash_page_read_sequencer: a randomized timing-controller and NAND model
// feeding expected command/address bytes and read words into scoreboard queues.
module tb_flash_page_read_sequencer;

  localparam int WCW   = 12;
  localparam int TWB_C = 8;
  localparam int TMO_C = 100;

  logic            i_master_clk = 1'b0;
  logic            i_reset_n;
  logic            i_page_request;
  logic [15:0]     i_col_addr;
  logic [23:0]     i_row_addr;
  logic [WCW-1:0]  i_word_count;
  logic            o_busy, o_done, o_error;
  logic [15:0]     o_data;
  logic            o_data_valid;
  logic            i_data_ready;
  logic            o_cmd_request;
  logic [7:0]      o_cmd_data;
  logic            i_cmd_done;
  logic            o_ad_request;
  logic [7:0]      o_ad_data;
  logic            i_ad_done;
  logic            o_rd_request;
  logic [15:0]     i_rd_data;
  logic            i_rd_data_valid;
  logic            i_chip_ready;
  logic [3:0]      o_fsm_state;

  flash_page_read_sequencer #(
    .WORD_COUNT_WIDTH(WCW), .TWB_CYCLES(TWB_C), .TIMEOUT_CYCLES(TMO_C)
  ) dut (
    .i_master_clk(i_master_clk), .i_reset_n(i_reset_n), .i_page_request(i_page_request),
    .i_col_addr(i_col_addr), .i_row_addr(i_row_addr), .i_word_count(i_word_count),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_data(o_data),
    .o_data_valid(o_data_valid), .i_data_ready(i_data_ready),
    .o_cmd_request(o_cmd_request), .o_cmd_data(o_cmd_data), .i_cmd_done(i_cmd_done),
    .o_ad_request(o_ad_request), .o_ad_data(o_ad_data), .i_ad_done(i_ad_done),
    .o_rd_request(o_rd_request), .i_rd_data(i_rd_data), .i_rd_data_valid(i_rd_data_valid),
    .i_chip_ready(i_chip_ready), .o_fsm_state(o_fsm_state)
  );

  // ---------------- clock / cycle bookkeeping ----------------
  always #5 i_master_clk = ~i_master_clk;

  int         cyc = 0;
  logic       dr_at_edge = 1'b0;
  logic [2:0] req_at_edge = 3'b000;

  always @(posedge i_master_clk) begin
    cyc++;
    dr_at_edge  = i_data_ready;
    req_at_edge = {o_cmd_request, o_ad_request, o_rd_request};
  end

  // ---------------- scoreboard state ----------------
  logic [7:0]  exp_cmd_q[$];
  logic [7:0]  exp_ad_q[$];
  logic [15:0] exp_q[$];
  int n_cmp = 0;
  int n_mis = 0;
  int n_cmd, n_ad, n_rd, n_valid;

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_cmp++;
    n_mis++;
    $display("FAIL %s: got 0x%0h, required nothing (t=%0t)", name, act, $time);
  endtask

  // ---------------- timing controller + NAND model + monitor ----------------
  logic [2:0]  cur;
  logic [2:0]  prev_neg = 3'b000;
  logic        done_driven = 1'b0;
  bit          tc_active = 0;
  int          tc_lat = 0;
  logic [7:0]  held_byte;
  logic [15:0] word;
  int          rdy_delay_cfg = 0;  // 0: R/B# stays high, -1: never returns, n: high after n cycles
  int          rdy_cnt = 0;
  int          dr_mode = 0;        // 0: always ready, 1: 3 low / 1 high, 2: random
  int          d30_edge = 0;
  bit          first_rd_pending = 0;

  always @(negedge i_master_clk) begin
    cur = {o_cmd_request, o_ad_request, o_rd_request};
    if (!i_reset_n) begin
      tc_active = 0; done_driven = 1'b0; prev_neg = 3'b000; rdy_cnt = 0;
      i_cmd_done = 1'b0; i_ad_done = 1'b0; i_rd_data_valid = 1'b0; i_chip_ready = 1'b1;
    end else begin
      if (cur != 3'b000) compare("one_request", $countones(cur), 1);
      if (done_driven) compare("low_after_done", cur, 0);
      else if (cur != 3'b000 && prev_neg != 3'b000) compare("no_switch_without_gap", cur, prev_neg);
      if (o_rd_request && !req_at_edge[0]) begin
        compare("rd_issue_gated", dr_at_edge, 1);
        if (first_rd_pending) begin
          compare("twb_guard", (cyc - d30_edge) > TWB_C, 1);
          first_rd_pending = 0;
        end
      end
      if (o_data_valid) begin
        n_valid++;
        if (exp_q.size() == 0) unexpected("unexpected_word", o_data);
        else compare("read_word", o_data, exp_q.pop_front());
      end

      if (rdy_cnt > 0) begin
        rdy_cnt--;
        if (rdy_cnt == 0) i_chip_ready = 1'b1;
      end
      case (dr_mode)
        0:       i_data_ready = 1'b1;
        1:       i_data_ready = ((cyc % 4) == 3);
        default: i_data_ready = 1'($urandom_range(0, 1));
      endcase

      // Re-triggers on any request still high after its done, like the real controller.
      done_driven = 1'b0; i_cmd_done = 1'b0; i_ad_done = 1'b0; i_rd_data_valid = 1'b0;
      if (cur == 3'b000) tc_active = 0;
      else begin
        if (!tc_active) begin
          tc_active = 1;
          tc_lat    = $urandom_range(0, 2);
          held_byte = o_cmd_request ? o_cmd_data : o_ad_data;
        end else tc_lat--;
        if (tc_lat <= 0) begin
          tc_active = 0;
          done_driven = 1'b1;
          case (cur)
            3'b100: begin
              n_cmd++;
              compare("cmd_stable", o_cmd_data, held_byte);
              if (exp_cmd_q.size() == 0) unexpected("unexpected_cmd", o_cmd_data);
              else compare("cmd_byte", o_cmd_data, exp_cmd_q.pop_front());
              i_cmd_done = 1'b1;
              if (o_cmd_data == 8'h30) begin
                d30_edge = cyc + 1;
                first_rd_pending = 1;
                if (rdy_delay_cfg == 0) i_chip_ready = 1'b1;
                else begin
                  i_chip_ready = 1'b0;
                  rdy_cnt = rdy_delay_cfg;
                end
              end
            end
            3'b010: begin
              n_ad++;
              compare("ad_stable", o_ad_data, held_byte);
              if (exp_ad_q.size() == 0) unexpected("unexpected_ad", o_ad_data);
              else compare("ad_byte", o_ad_data, exp_ad_q.pop_front());
              i_ad_done = 1'b1;
            end
            3'b001: begin
              n_rd++;
              word = 16'($urandom);
              i_rd_data = word;
              i_rd_data_valid = 1'b1;
              exp_q.push_back(word);
            end
            default: ;
          endcase
        end
      end
      prev_neg = cur;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_outputs_zero(input string name);
    compare({name, "_flags"}, {o_busy, o_done, o_error, o_data_valid,
                               o_cmd_request, o_ad_request, o_rd_request}, 0);
    compare({name, "_bytes"}, {o_data, o_cmd_data, o_ad_data}, 0);
  endtask

  task automatic push_expected(input logic [15:0] col, input logic [23:0] row);
    exp_cmd_q.push_back(8'h00);
    exp_cmd_q.push_back(8'h30);
    exp_ad_q.push_back(col[7:0]);
    exp_ad_q.push_back(col[15:8]);
    exp_ad_q.push_back(row[7:0]);
    exp_ad_q.push_back(row[15:8]);
    exp_ad_q.push_back(row[23:16]);
  endtask

  task automatic start_req(input logic [15:0] col, input logic [23:0] row, input int cnt);
    n_cmd = 0; n_ad = 0; n_rd = 0; n_valid = 0;
    push_expected(col, row);
    @(negedge i_master_clk);
    i_col_addr = col; i_row_addr = row; i_word_count = cnt[WCW-1:0]; i_page_request = 1'b1;
    @(negedge i_master_clk);
    i_page_request = 1'b0;
    i_col_addr = 16'($urandom); i_row_addr = 24'($urandom); i_word_count = 12'($urandom);
    compare("busy_after_start", o_busy, 1);
  endtask

  task automatic apply_reset();
    i_reset_n = 1'b0;
    exp_cmd_q.delete(); exp_ad_q.delete(); exp_q.delete();
    repeat (3) @(negedge i_master_clk);
    i_reset_n = 1'b1;
  endtask

  task automatic run_req(input logic [15:0] col, input logic [23:0] row, input int cnt,
                         input int rdy_delay, input int drm, input bit expect_err, input bit poke);
    bit seen;
    rdy_delay_cfg = rdy_delay;
    dr_mode = drm;
    start_req(col, row, cnt);
    seen = 0;
    for (int k = 0; k < 6000 && !seen; k++) begin
      @(negedge i_master_clk);
      if (poke) i_page_request = (k == 5);
      if (o_done || o_error) seen = 1;
    end
    i_page_request = 1'b0;
    if (!seen) begin
      unexpected("completion_timeout", {o_busy, o_done, o_error});
      apply_reset();
    end else begin
      compare("done_pulse", o_done, !expect_err);
      compare("error_pulse", o_error, expect_err);
      compare("busy_cleared", o_busy, 0);
      // tWB guard, then the full ready-low window, then one cycle to raise the pulse.
      if (expect_err) compare("timeout_cycle", cyc - d30_edge, TWB_C + TMO_C + 1);
      compare("cmd_count", n_cmd, 2);
      compare("ad_count", n_ad, 5);
      compare("read_count", n_rd, expect_err ? 0 : cnt);
      compare("word_count", n_valid, expect_err ? 0 : cnt);
      @(negedge i_master_clk);
      compare("single_pulse", {o_done, o_error, o_busy}, 0);
      compare("queues_drained", exp_cmd_q.size() + exp_ad_q.size() + exp_q.size(), 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit hit;
    i_reset_n = 1'b0; i_page_request = 1'b0; i_col_addr = '0; i_row_addr = '0;
    i_word_count = '0; i_rd_data = '0; i_data_ready = 1'b1;
    i_cmd_done = 1'b0; i_ad_done = 1'b0; i_rd_data_valid = 1'b0; i_chip_ready = 1'b1;
    repeat (3) @(negedge i_master_clk);
    check_outputs_zero("reset_state");
    i_reset_n = 1'b1;
    repeat (2) @(negedge i_master_clk);

    run_req(16'h0123, 24'h045678, 4, TWB_C + 2, 0, 0, 0);
    run_req(16'hBEEF, 24'h00CAFE, 3, 0, 0, 0, 0);             // R/B# never drops
    run_req(16'h5A5A, 24'hA5A5A5, 5, -1, 0, 1, 0);            // ready timeout
    run_req(16'h3C3C, 24'h123456, 8, 5, 1, 0, 0);             // 3 low / 1 high
    run_req(16'h7777, 24'h010203, 0, 4, 0, 0, 1);             // zero words, poked while busy

    // Reset while the third address byte is on the bus.
    rdy_delay_cfg = 3; dr_mode = 0;
    start_req(16'hA1B2, 24'hC3D4E5, 3);
    hit = 0;
    for (int k = 0; k < 300 && !hit; k++) begin
      @(negedge i_master_clk);
      if (o_ad_request && o_ad_data == 8'hE5) hit = 1;
    end
    compare("reached_addr_index2", hit, 1);
    #2 i_reset_n = 1'b0;
    #1 check_outputs_zero("async_reset");
    apply_reset();
    repeat (2) @(negedge i_master_clk);
    run_req(16'h2468, 24'h13579B, 5, 6, 0, 0, 0);

    for (int t = 0; t < 6; t++)
      run_req(16'($urandom), 24'($urandom), $urandom_range(0, 12),
              $urandom_range(0, 60), 2, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #1000000;
    n_cmp++;
    n_mis++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
